// File: rtl/mem_dma.sv
// Block-copy bus initiator: reads one word from src, writes it to dst, repeats
// for len elements while enforcing the system memory map.
module mem_dma #(
    parameter int LEN_W  = 16,
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic [31:0]      mem_addr,
    output logic             mem_wen,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [31:0] STEP = 32'(STRIDE);

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    // RAM, ROM and IO windows are contiguous from 0 up to the top of IO.
    function automatic logic is_mapped(input logic [31:0] addr);
        return addr <= 32'h0008_03FF;
    endfunction

    function automatic logic is_rom(input logic [31:0] addr);
        return (addr >= 32'h0004_0000) && (addr <= 32'h0007_FFFF);
    endfunction

    // NOTE: every output and next-state variable gets a default before the case
    // so no path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        buf_d     = buf_q;
        rem_d     = rem_q;
        err_d     = err_q;
        mem_addr  = 32'h0;
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    rem_d   = len;
                    err_d   = 1'b0;
                    state_d = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy     = 1'b1;
                mem_addr = src_q;
                if (!is_mapped(src_q)) begin
                    state_d = S_ERR;
                end else begin
                    buf_d   = mem_rdata;
                    src_d   = src_q + STEP;
                    state_d = abort ? S_IDLE : S_WRITE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = buf_q;
                if (!is_mapped(dst_q) || is_rom(dst_q)) begin
                    state_d = S_ERR;
                end else begin
                    mem_wen = 1'b1;
                    dst_d   = dst_q + STEP;
                    rem_d   = rem_q - LEN_W'(1);
                    if (abort)                    state_d = S_IDLE;
                    else if (rem_q == LEN_W'(1))  state_d = S_DONE;
                    else                          state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // mem_wen is decoded from state_q, so the async reset drops it at once and
    // no partial write can land on the following edge.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            buf_q   <= 32'h0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign err       = err_q;
    assign remaining = rem_q;

endmodule
